// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with debounce, 16-bit digit entry word and a
// debounced Enter button that strobes CNTRPIN to the hex input encoder.
module hex_keypad_entry #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [3:0]  Row,
  output logic [3:0]  Col,
  input  logic        EnterBtn,
  output logic [15:0] HEXIN,
  output logic        CNTRPIN,
  output logic        KeyStrobe,
  output logic [2:0]  DigCnt
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned DebW   = $clog2(DEBOUNCE + 1);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e            state_q, state_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_q, col_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [DebW-1:0]   deb_q, deb_d;
  logic [3:0]        cap_q, cap_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic              pend_q, pend_d;
  logic [3:0]        pend_key_q, pend_key_d;
  logic [15:0]       hexin_q, hexin_d;
  logic [2:0]        digcnt_q, digcnt_d;
  logic              fresh_q, fresh_d;
  logic              ks_q, ks_d;
  logic              en_db_q, en_db_d;
  logic [DebW-1:0]   en_cnt_q, en_cnt_d;
  logic              cp_q, cp_d;
  logic              cp_p_q;
  logic [3:0]        row_s1_q, srow;
  logic              en_s1_q, en_s2_q;

  logic [3:0] row_low;
  logic       one_low;
  logic [1:0] row_enc;
  logic       accept, apply, window;
  logic [3:0] key_ap;

  assign Col       = col_q;
  assign HEXIN     = hexin_q;
  assign CNTRPIN   = cp_q;
  assign KeyStrobe = ks_q;
  assign DigCnt    = digcnt_q;

  always_comb begin
    row_low = ~srow;
    one_low = (row_low != 4'h0) && ((row_low & (row_low - 4'h1)) == 4'h0);
    row_enc = 2'd0;
    unique case (row_low)
      4'b0010: row_enc = 2'd1;
      4'b0100: row_enc = 2'd2;
      4'b1000: row_enc = 2'd3;
      default: row_enc = 2'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    dwell_d    = dwell_q;
    deb_d      = deb_q;
    cap_d      = cap_q;
    row_idx_d  = row_idx_q;
    pend_d     = pend_q;
    pend_key_d = pend_key_q;
    hexin_d    = hexin_q;
    digcnt_d   = digcnt_q;
    fresh_d    = fresh_q;
    en_db_d    = en_db_q;
    en_cnt_d   = en_cnt_q;
    ks_d       = 1'b0;
    cp_d       = 1'b0;
    accept     = 1'b0;
    apply      = 1'b0;
    key_ap     = pend_key_q;

    unique case (state_q)
      StScan: begin
        if (dwell_q == DwellLast) begin
          dwell_d = '0;
          if (one_low) begin
            cap_d     = srow;
            row_idx_d = row_enc;
            deb_d     = DebW'(1);
            state_d   = StDebounce;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      StDebounce: begin
        if (srow != cap_q) begin
          state_d = StScan;
          dwell_d = '0;
        end else if ((32'(deb_q) + 32'd1) >= DEBOUNCE) begin
          accept  = 1'b1;
          state_d = StHeld;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StHeld: begin
        if (srow == 4'hF) begin
          deb_d   = DebW'(1);
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (srow != 4'hF) begin
          state_d = StHeld;
        end else if ((32'(deb_q) + 32'd1) >= DEBOUNCE) begin
          state_d   = StScan;
          dwell_d   = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = StScan;
    endcase

    // HEXIN is frozen while CNTRPIN is high and for the cycle after; a digit
    // accepted in that window is parked and written once the window closes.
    window = cp_q | cp_p_q;
    if (accept) begin
      if (window) begin
        pend_d     = 1'b1;
        pend_key_d = {row_idx_q, col_idx_q};
      end else begin
        apply  = 1'b1;
        key_ap = {row_idx_q, col_idx_q};
      end
    end else if (pend_q && !window) begin
      apply  = 1'b1;
      pend_d = 1'b0;
    end

    if (apply) begin
      ks_d = 1'b1;
      if (fresh_q) begin
        hexin_d  = {12'h000, key_ap};
        digcnt_d = 3'd1;
        fresh_d  = 1'b0;
      end else begin
        hexin_d  = {hexin_q[11:0], key_ap};
        digcnt_d = (digcnt_q >= 3'd4) ? 3'd4 : digcnt_q + 3'd1;
      end
    end

    // Enter edge is evaluated after the digit so it wins on DigCnt/fresh.
    if (en_s2_q != en_db_q) begin
      if ((32'(en_cnt_q) + 32'd1) >= DEBOUNCE) begin
        en_db_d  = en_s2_q;
        en_cnt_d = '0;
        if (en_s2_q) begin
          cp_d     = 1'b1;
          fresh_d  = 1'b1;
          digcnt_d = 3'd0;
        end
      end else begin
        en_cnt_d = en_cnt_q + 1'b1;
      end
    end else begin
      en_cnt_d = '0;
    end

    col_d = ~(4'b0001 << col_idx_d);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      row_s1_q   <= 4'hF;
      srow       <= 4'hF;
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      state_q    <= StScan;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      dwell_q    <= '0;
      deb_q      <= '0;
      cap_q      <= 4'hF;
      row_idx_q  <= 2'd0;
      pend_q     <= 1'b0;
      pend_key_q <= 4'h0;
      hexin_q    <= 16'h0000;
      digcnt_q   <= 3'd0;
      fresh_q    <= 1'b0;
      ks_q       <= 1'b0;
      en_db_q    <= 1'b0;
      en_cnt_q   <= '0;
      cp_q       <= 1'b0;
      cp_p_q     <= 1'b0;
    end else begin
      row_s1_q   <= Row;
      srow       <= row_s1_q;
      en_s1_q    <= EnterBtn;
      en_s2_q    <= en_s1_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      dwell_q    <= dwell_d;
      deb_q      <= deb_d;
      cap_q      <= cap_d;
      row_idx_q  <= row_idx_d;
      pend_q     <= pend_d;
      pend_key_q <= pend_key_d;
      hexin_q    <= hexin_d;
      digcnt_q   <= digcnt_d;
      fresh_q    <= fresh_d;
      ks_q       <= ks_d;
      en_db_q    <= en_db_d;
      en_cnt_q   <= en_cnt_d;
      cp_q       <= cp_d;
      cp_p_q     <= cp_q;
    end
  end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Directed bench for hex_keypad_entry: a keypad matrix model drives Row from Col
// and a pressed-key vector; every expectation below is hand-derived.
module tb_hex_keypad_entry;

  logic        Clk = 1'b0;
  logic        Clr;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic        EnterBtn;
  logic [15:0] HEXIN;
  logic        CNTRPIN;
  logic        KeyStrobe;
  logic [2:0]  DigCnt;

  logic [15:0] pressed;   // bit r*4+c = key at row r, column c held down
  int total  = 0;
  int passed = 0;
  int failed = 0;
  int ks_cnt = 0;
  int cp_cnt = 0;

  hex_keypad_entry #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .Row      (Row),
    .Col      (Col),
    .EnterBtn (EnterBtn),
    .HEXIN    (HEXIN),
    .CNTRPIN  (CNTRPIN),
    .KeyStrobe(KeyStrobe),
    .DigCnt   (DigCnt)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    Row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if ((pressed[r*4 +: 4] & ~Col) != 4'h0) Row[r] = 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (KeyStrobe === 1'b1) ks_cnt++;
    if (CNTRPIN === 1'b1) cp_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Press key (r,c), wait for its strobe, hold a while, then release.
  task automatic press_key(input int r, input int c, input logic [15:0] exp, input string tag);
    int found;
    found = 0;
    pressed[r*4+c] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (KeyStrobe === 1'b1) begin
        found = 1;
        break;
      end
    end
    check({tag, "_strobe"}, found, 1);
    check({tag, "_hexin"}, HEXIN, exp);
    tick(12);
    pressed[r*4+c] = 1'b0;
    tick(15);
  endtask

  initial begin
    int ks_base;
    int cp_base;
    int found;
    Clr      = 1'b0;
    EnterBtn = 1'b0;
    pressed  = 16'h0000;

    // Reset and idle scan
    tick(3);
    check("rst_col", Col, 4'b1110);
    check("rst_hexin", HEXIN, 16'h0000);
    check("rst_cntrpin", CNTRPIN, 1'b0);
    check("rst_keystrobe", KeyStrobe, 1'b0);
    check("rst_digcnt", DigCnt, 3'd0);
    ks_base = ks_cnt;
    cp_base = cp_cnt;
    Clr = 1'b1;
    tick(2);  check("idle_col0", Col, 4'b1110);
    tick(4);  check("idle_col1", Col, 4'b1101);
    tick(4);  check("idle_col2", Col, 4'b1011);
    tick(4);  check("idle_col3", Col, 4'b0111);
    tick(4);  check("idle_wrap", Col, 4'b1110);
    tick(46);
    check("idle_hexin", HEXIN, 16'h0000);
    check("idle_no_keystrobe", ks_cnt - ks_base, 0);
    check("idle_no_cntrpin", cp_cnt - cp_base, 0);

    // Four clean digits
    ks_base = ks_cnt;
    press_key(0, 1, 16'h0001, "dig1");
    press_key(2, 2, 16'h001A, "digA");
    press_key(0, 3, 16'h01A3, "dig3");
    press_key(3, 3, 16'h1A3F, "digF");
    check("four_keystrobes", ks_cnt - ks_base, 4);
    check("four_digcnt", DigCnt, 3'd4);

    // Enter strobe, HEXIN held across it
    cp_base  = cp_cnt;
    EnterBtn = 1'b1;
    found    = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (CNTRPIN === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("enter_strobe_seen", found, 1);
    check("enter_hexin_at", HEXIN, 16'h1A3F);
    check("enter_digcnt", DigCnt, 3'd0);
    tick(1);
    check("enter_one_cycle", CNTRPIN, 1'b0);
    check("enter_hexin_after", HEXIN, 16'h1A3F);
    tick(14);
    EnterBtn = 1'b0;
    tick(10);
    check("enter_single_pulse", cp_cnt - cp_base, 1);
    press_key(1, 3, 16'h0007, "dig7_fresh");
    check("fresh_digcnt", DigCnt, 3'd1);

    // Bounce on row 1 / column 2
    ks_base = ks_cnt;
    for (int i = 0; i < 10; i++) begin
      pressed[6] = ~pressed[6];
      tick(1);
    end
    check("bounce_no_strobe", ks_cnt - ks_base, 0);
    press_key(1, 2, 16'h0076, "dig6_bounce");
    check("bounce_one_digit", ks_cnt - ks_base, 1);

    // Ghost: rows 0 and 1 low on column 0
    ks_base = ks_cnt;
    pressed = 16'h0011;
    tick(40);
    check("ghost_no_strobe", ks_cnt - ks_base, 0);
    check("ghost_hexin", HEXIN, 16'h0076);
    pressed = 16'h0000;
    tick(10);

    // Overflow: five digits
    press_key(0, 1, 16'h0761, "ovf1");
    press_key(0, 2, 16'h7612, "ovf2");
    press_key(0, 3, 16'h6123, "ovf3");
    press_key(1, 0, 16'h1234, "ovf4");
    press_key(1, 1, 16'h2345, "ovf5");
    check("ovf_digcnt", DigCnt, 3'd4);

    // Async reset two cycles into debounce of key 9 (row 2, column 1)
    Clr = 1'b0;
    pressed[9] = 1'b1;
    tick(2);
    ks_base = ks_cnt;
    Clr = 1'b1;
    tick(9);
    check("mid_deb_no_strobe_yet", ks_cnt - ks_base, 0);
    cp_base = cp_cnt;
    Clr = 1'b0;
    #1;
    check("async_hexin", HEXIN, 16'h0000);
    check("async_col", Col, 4'b1110);
    check("async_cntrpin", CNTRPIN, 1'b0);
    check("async_digcnt", DigCnt, 3'd0);
    tick(3);
    Clr = 1'b1;

    // After release, Enter edge lands one cycle before the digit accept
    tick(4);
    check("release_col", Col, 4'b1101);
    EnterBtn = 1'b1;
    tick(5);
    check("coll_cntrpin", CNTRPIN, 1'b1);
    check("coll_no_glitch", cp_cnt - cp_base, 0);
    check("coll_hexin_at", HEXIN, 16'h0000);
    tick(1);
    check("coll_deferred_strobe", KeyStrobe, 1'b0);
    check("coll_hexin_after", HEXIN, 16'h0000);
    tick(1);
    check("coll_hexin_hold2", HEXIN, 16'h0000);
    tick(1);
    check("coll_late_strobe", KeyStrobe, 1'b1);
    check("coll_late_hexin", HEXIN, 16'h0009);
    check("coll_late_digcnt", DigCnt, 3'd1);
    EnterBtn = 1'b0;
    pressed  = 16'h0000;
    tick(10);
    check("coll_cntrpin_count", cp_cnt - cp_base, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
